// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants and types for the six-digit 7-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    typedef logic [2:0] digit_idx_t;

    localparam digit_idx_t LAST_IDX = 3'(NUM_DIGITS - 1);

    // Active-low one-hot anode pattern for the selected digit.
    function automatic logic [NUM_DIGITS-1:0] anode_enable(input digit_idx_t idx);
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes show a dash.
module bcd_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every path assigns seg (via the default arm), so no latch is inferred.
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode driver for six BCD time digits with a
// per-slot dead cycle, frame-coherent snapshot, blink and leading-zero blanking.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV  = 16,
    parameter int BLINK_DIV = 512,
    parameter bit LZ_BLANK  = 1'b1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            s1,
    input  logic [3:0]            s2,
    input  logic [3:0]            m1,
    input  logic [3:0]            m2,
    input  logic [3:0]            h1,
    input  logic [3:0]            h2,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [CW-1:0]  cnt;
    digit_idx_t     idx;
    logic [BW-1:0]  blink_cnt;
    logic           blink_ph;
    logic [3:0]     sh_s1, sh_s2, sh_m1, sh_m2, sh_h1, sh_h2;

    logic           tick;
    logic [3:0]     cur_digit;
    logic [6:0]     cur_seg;
    logic           blank_digit;
    logic           dp_lit;

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == LAST_IDX) ? '0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow copy changes only at the frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the shadow bank is small and its reset-to-zero contents are visible (first frame shows zeros), so it is reset.
        if (!reset) begin
            sh_s1 <= '0;
            sh_s2 <= '0;
            sh_m1 <= '0;
            sh_m2 <= '0;
            sh_h1 <= '0;
            sh_h2 <= '0;
        end else if (tick && idx == LAST_IDX) begin
            sh_s1 <= s1;
            sh_s2 <= s2;
            sh_m1 <= m1;
            sh_m2 <= m2;
            sh_h1 <= h1;
            sh_h2 <= h2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_MAX) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    always_comb begin
        cur_digit = '0;
        case (idx)
            3'd0:    cur_digit = sh_s1;
            3'd1:    cur_digit = sh_s2;
            3'd2:    cur_digit = sh_m1;
            3'd3:    cur_digit = sh_m2;
            3'd4:    cur_digit = sh_h1;
            3'd5:    cur_digit = sh_h2;
            default: cur_digit = '0;
        endcase
    end

    bcd_to_seg7 u_decode (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        blank_digit = (blink_ph && blink_mask[idx])
                   || (LZ_BLANK && idx == LAST_IDX && sh_h2 == 4'd0);
        dp_lit      = (idx == 3'd2 || idx == 3'd4) && !sh_s1[0];
    end

    // cnt==0 is the dead cycle: anodes released before the next digit is driven.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (cnt == '0 || blank_digit) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= anode_enable(idx);
            seg <= cur_seg;
            dp  <= ~dp_lit;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: cycle-count reference model of the scan, snapshot, blink and blanking rules.
module tb_seg7_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;
    localparam int FRAME     = SCAN_DIV * 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s1, s2, m1, m2, h1, h2;
    logic [5:0] blink_mask;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int         total = 0;
    int         bad = 0;
    int         pos = 0;
    logic [3:0] sh [6];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV),
        .LZ_BLANK  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s1         (s1),
        .s2         (s2),
        .m1         (m1),
        .m2         (m2),
        .h1         (h1),
        .h2         (h2),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    function automatic logic [3:0] in_digit(input int i);
        case (i)
            0:       return s1;
            1:       return s2;
            2:       return m1;
            3:       return m2;
            4:       return h1;
            default: return h2;
        endcase
    endfunction

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at pos=%0d: observed=%0h expected=%0h", tag, pos, obs, exp);
        end
    endtask

    // One clock: derive the expected registered outputs from the cycle count since reset release.
    task automatic step();
        int         c;
        int         i;
        bit         ph;
        bit         blank;
        logic [5:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic [3:0] nxt [6];
        c     = pos % SCAN_DIV;
        i     = (pos / SCAN_DIV) % 6;
        ph    = ((pos / BLINK_DIV) % 2) == 1;
        blank = (c == 0) || (ph && blink_mask[i]) || (i == 5 && sh[5] == 4'd0);
        ean   = 6'h3F;
        eseg  = 7'h7F;
        edp   = 1'b1;
        if (!blank) begin
            ean  = 6'h3F & ~(6'd1 << i);
            eseg = ref_seg(sh[i]);
            edp  = !((i == 2 || i == 4) && sh[0][0] == 1'b0);
        end
        nxt = sh;
        if (pos % FRAME == FRAME - 1)
            for (int k = 0; k < 6; k++) nxt[k] = in_digit(k);
        @(posedge clk);
        pos++;
        sh = nxt;
        #1;
        check("an", 16'(an), 16'(ean));
        check("seg", 16'(seg), 16'(eseg));
        check("dp", 16'(dp), 16'(edp));
        check("one_anode", 16'($countones(~an) <= 1), 16'd1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] e, input logic [3:0] f);
        s1 = a; s2 = b; m1 = c; m2 = d; h1 = e; h2 = f;
    endtask

    task automatic model_reset();
        pos = 0;
        for (int k = 0; k < 6; k++) sh[k] = 4'd0;
    endtask

    initial begin
        int guard;
        set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4);
        blink_mask = 6'b0;
        model_reset();

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 16'(an), 16'h3F);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        #2 reset = 1'b1;

        // First frame shows zeros even though inputs are non-zero.
        step();
        step();
        check("first_drive_an", 16'(an), 16'h3E);
        check("first_drive_seg", 16'(seg), 16'h40);
        run(FRAME + 10);

        // Reset mid-drive: outputs must blank without waiting for a clock.
        guard = 0;
        while (an == 6'h3F && guard < FRAME) begin
            step();
            guard++;
        end
        check("found_drive", 16'(an != 6'h3F), 16'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_an", 16'(an), 16'h3F);
        check("async_rst_seg", 16'(seg), 16'h7F);
        check("async_rst_dp", 16'(dp), 16'h1);
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        run(2);
        check("restart_seg", 16'(seg), 16'h40);

        // Scan of 1..6 through full frames.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        run(2 * FRAME);

        // Coherence: s1 changes while digit 3 is on.
        guard = 0;
        while (((pos / SCAN_DIV) % 6) != 3 && guard < FRAME) begin
            step();
            guard++;
        end
        s1 = 4'd2;
        run(2 * FRAME);

        // Invalid BCD shows a dash.
        m1 = 4'hC;
        run(2 * FRAME);
        m1 = 4'd3;

        // Blink on digits 0 and 1 across both phases.
        blink_mask = 6'b000011;
        run(3 * FRAME);
        blink_mask = 6'b0;

        // Leading-zero suppression and dp rule.
        h2 = 4'd0;
        run(2 * FRAME);
        h2 = 4'd1;
        run(2 * FRAME);
        s1 = 4'd4;
        run(2 * FRAME);
        s1 = 4'd5;
        run(2 * FRAME);

        // Randomized digits and masks changing at arbitrary points in the frame.
        for (int r = 0; r < 40; r++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)));
            blink_mask = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
            run($urandom_range(1, 30));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
